// File: rtl/mux_arb_n_if.sv
// Handshake bundle between the mux_arb_n block and its producers/consumer.
interface mux_arb_n_if #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 8
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          controlador;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    // Environment side: drives channel offers, mode and downstream ready.
    modport master (
        output mode, controlador, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    // Block side.
    modport slave (
        input  mode, controlador, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel mux/arbiter: direct select or round-robin into a single-entry output register.
module mux_arb_n #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 8
) (
    input logic        clk,
    input logic        reset_n,
    mux_arb_n_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [SEL_W-1:0]    ptr;
    logic                can_accept;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    rr_idx;
    logic                found;
    logic                xfer;
    logic [WIDTH-1:0]    sel_data;

    // Output register can take a new entry when empty or draining this cycle.
    always_comb can_accept = !bus.out_valid || bus.out_ready;

    // Grant decision: one-hot from controlador in mode 0, first valid from ptr in mode 1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        rr_idx    = '0;
        found     = 1'b0;
        if (!bus.mode) begin
            // Out-of-range controlador matches no channel, so nothing is granted.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == bus.controlador) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                rr_idx = SEL_W'((32'(ptr) + 32'(k)) % CHANNELS);
                if (!found && bus.in_valid[rr_idx]) begin
                    found         = 1'b1;
                    grant[rr_idx] = 1'b1;
                    grant_idx     = rr_idx;
                end
            end
        end
    end

    // Ready is the grant qualified by space in the output register and reset.
    always_comb bus.in_ready = grant & {CHANNELS{can_accept && reset_n}};

    // A transfer happens on the single ready channel when it is also valid.
    always_comb xfer = |(bus.in_valid & bus.in_ready);

    // Data of the granted channel; only feeds the output register.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_sel   <= grant_idx;
                if (bus.mode) begin
                    if (grant_idx == SEL_W'(CHANNELS - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_idx + SEL_W'(1);
                    end
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n at default and non-default parameters.
module tb_mux_arb_n;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    mux_arb_n_if #(.WIDTH(5),  .CHANNELS(8)) a ();
    mux_arb_n_if #(.WIDTH(32), .CHANNELS(5)) b ();

    mux_arb_n #(.WIDTH(5), .CHANNELS(8)) u_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a.slave)
    );

    mux_arb_n #(.WIDTH(32), .CHANNELS(5)) u_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] da(input int i);
        return 5'(18 + i);
    endfunction

    function automatic logic [31:0] db(input int i);
        return 32'(32'hA000_0000 + 32'(i * 17));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        a.mode = 1'b0; a.controlador = '0; a.in_valid = '0; a.out_ready = 1'b1;
        b.mode = 1'b0; b.controlador = '0; b.in_valid = '0; b.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) a.in_data[i*5 +: 5] = da(i);
        for (int i = 0; i < 5; i++) b.in_data[i*32 +: 32] = db(i);

        // Reset state, including ready gating while reset is held.
        #3;
        chk("rst_out_valid", 64'(a.out_valid), 64'(0));
        chk("rst_out_data",  64'(a.out_data),  64'(0));
        chk("rst_out_sel",   64'(a.out_sel),   64'(0));
        chk("rst_in_ready",  64'(a.in_ready),  64'(0));
        tick();

        // Direct select of channel 3 on the first edge after release.
        reset_n = 1'b1;
        a.mode = 1'b0; a.controlador = 3'd3; a.in_valid = 8'hFF;
        #1;
        chk("dir_in_ready", 64'(a.in_ready), 64'(8'h08));
        tick();
        chk("dir_out_valid", 64'(a.out_valid), 64'(1));
        chk("dir_out_data",  64'(a.out_data),  64'(5'h15));
        chk("dir_out_sel",   64'(a.out_sel),   64'(3));

        // Back-pressure holds the entry and blocks all ready bits.
        a.out_ready = 1'b0;
        a.in_data[3*5 +: 5] = 5'h07;
        #1;
        chk("bp_in_ready0", 64'(a.in_ready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", 64'(a.in_ready),  64'(0));
            chk("bp_out_data", 64'(a.out_data),  64'(5'h15));
            chk("bp_out_sel",  64'(a.out_sel),   64'(3));
            chk("bp_valid",    64'(a.out_valid), 64'(1));
        end
        a.in_data[3*5 +: 5] = da(3);

        // Drain and reload in the same cycle: no bubble.
        a.out_ready = 1'b1; a.controlador = 3'd1; a.in_valid = 8'h02;
        #1;
        chk("reload_in_ready", 64'(a.in_ready), 64'(8'h02));
        tick();
        chk("reload_valid", 64'(a.out_valid), 64'(1));
        chk("reload_data",  64'(a.out_data),  64'(5'h13));
        chk("reload_sel",   64'(a.out_sel),   64'(1));

        // Mode-0 ready ignores in_valid; pure drain clears out_valid.
        a.in_valid = 8'h00;
        #1;
        chk("dir_ready_novalid", 64'(a.in_ready), 64'(8'h02));
        tick();
        chk("drain_valid", 64'(a.out_valid), 64'(0));

        // Round-robin fairness from ptr 0 (mode 0 left ptr alone).
        a.mode = 1'b1; a.in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_in_ready", 64'(a.in_ready), 64'(1) << (k % 8));
            tick();
            chk("rr_out_sel",  64'(a.out_sel),   64'(k % 8));
            chk("rr_out_data", 64'(a.out_data),  64'(da(k % 8)));
            chk("rr_valid",    64'(a.out_valid), 64'(1));
        end

        // ptr is 2: grant ch5 to move ptr to 6.
        a.in_valid = 8'h20;
        #1;
        chk("rr_ch5_ready", 64'(a.in_ready), 64'(8'h20));
        tick();
        chk("rr_ch5_sel", 64'(a.out_sel), 64'(5));

        // Wrap and skip: ch0, ch2, ch0.
        a.in_valid = 8'b0000_0101;
        #1;
        chk("wrap1_ready", 64'(a.in_ready), 64'(8'h01));
        tick();
        chk("wrap1_sel", 64'(a.out_sel), 64'(0));
        chk("wrap2_ready", 64'(a.in_ready), 64'(8'h04));
        tick();
        chk("wrap2_sel", 64'(a.out_sel), 64'(2));
        chk("wrap3_ready", 64'(a.in_ready), 64'(8'h01));
        tick();
        chk("wrap3_sel", 64'(a.out_sel), 64'(0));

        // Mode 1 with nothing valid: no ready, register drains.
        a.in_valid = 8'h00;
        #1;
        chk("rr_idle_ready", 64'(a.in_ready), 64'(0));
        tick();
        chk("rr_idle_valid", 64'(a.out_valid), 64'(0));

        // ptr is 1: ch4 leaves ptr at 5 with an entry held.
        a.in_valid = 8'h10;
        tick();
        chk("pre_rst_valid", 64'(a.out_valid), 64'(1));
        chk("pre_rst_sel",   64'(a.out_sel),   64'(4));
        a.out_ready = 1'b0; a.in_valid = 8'hFF;
        #1;
        chk("pre_rst_ready", 64'(a.in_ready), 64'(0));

        // Asynchronous reset between edges discards the entry and ptr.
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(a.out_valid), 64'(0));
        chk("arst_data",  64'(a.out_data),  64'(0));
        chk("arst_sel",   64'(a.out_sel),   64'(0));
        chk("arst_ready", 64'(a.in_ready),  64'(0));
        #1;
        reset_n = 1'b1; a.out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(a.in_ready), 64'(8'h01));
        tick();
        chk("post_rst_sel",   64'(a.out_sel),   64'(0));
        chk("post_rst_data",  64'(a.out_data),  64'(da(0)));
        a.in_valid = 8'h00;

        // Non-default parameters: out-of-range direct select.
        b.mode = 1'b0; b.controlador = 3'd6; b.in_valid = 5'h1F;
        #1;
        chk("b_oor_ready", 64'(b.in_ready), 64'(0));
        tick();
        chk("b_oor_valid", 64'(b.out_valid), 64'(0));

        // Non-default parameters: round-robin cycles 0..4.
        b.mode = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("b_rr_ready", 64'(b.in_ready), 64'(1) << (k % 5));
            tick();
            chk("b_rr_sel",  64'(b.out_sel),  64'(k % 5));
            chk("b_rr_data", 64'(b.out_data), 64'(db(k % 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
